// File: rtl/sd_mgr_pkg.sv
// Shared types and sizing for the SD block manager.
package sd_mgr_pkg;

   localparam int unsigned WORDS_PER_BLOCK = 128;
   localparam int unsigned ADDR_W          = 7;
   localparam int unsigned LBA_W           = 32;
   localparam int unsigned WORD_W          = 32;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_FILL,
      RD_GO,
      WR_REQ,
      WR_STREAM,
      WR_ACK,
      WR_DONE
   } state_t;

endpackage

// File: rtl/sd_mgr_wr_stream.sv
// Write-BRAM reader feeding a valid/ready stream: absorbs the 1-cycle BRAM latency
// through a 2-entry skid FIFO and flags the block's last accepted beat.
module sd_mgr_wr_stream #(
   parameter int unsigned WORDS = sd_mgr_pkg::WORDS_PER_BLOCK,
   parameter int unsigned AW    = sd_mgr_pkg::ADDR_W
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic                          clear,
   input  logic [sd_mgr_pkg::WORD_W-1:0] bram_q,
   output logic [AW-1:0]                 bram_addr,
   output logic                          valid,
   input  logic                          ready,
   output logic [sd_mgr_pkg::WORD_W-1:0] data,
   output logic                          last
);
   import sd_mgr_pkg::*;

   logic [AW:0]         rd_cnt;
   logic [AW:0]         sent;
   logic                inflight;
   logic                active;
   logic [WORD_W-1:0]   mem [2];
   logic                rptr;
   logic                wptr;
   logic [1:0]          count;
   logic                push;
   logic                pop;
   logic                issue;

   assign push      = inflight;
   assign pop       = valid & ready;
   assign valid     = (count != 2'd0);
   assign data      = valid ? mem[rptr] : '0;
   assign bram_addr = rd_cnt[AW-1:0];
   assign last      = pop & (sent == (AW+1)'(WORDS - 1));
   // Only issue a read if the word it returns next cycle is guaranteed a FIFO slot.
   assign issue     = active & (rd_cnt < (AW+1)'(WORDS)) &
                      ((3'(count) + 3'(inflight)) <= (3'd1 + 3'(pop)));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_cnt   <= '0;
         sent     <= '0;
         inflight <= 1'b0;
         active   <= 1'b0;
         rptr     <= 1'b0;
         wptr     <= 1'b0;
         count    <= '0;
      end else if (start || clear) begin
         rd_cnt   <= '0;
         sent     <= '0;
         inflight <= 1'b0;
         active   <= start;
         rptr     <= 1'b0;
         wptr     <= 1'b0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) rd_cnt <= rd_cnt + (AW+1)'(1);
         if (push) begin
            mem[wptr] <= bram_q;
            wptr      <= ~wptr;
         end
         if (pop) begin
            rptr <= ~rptr;
            sent <= sent + (AW+1)'(1);
         end
         count <= count + {1'b0, push} - {1'b0, pop};
         if (last) active <= 1'b0;
      end
   end

endmodule

// File: rtl/sd_block_mgr.sv
// Block manager: services link read/write block requests against a host port.
// Optional host watchdog enabled by defining SD_MGR_TIMEOUT_EN.
module sd_block_mgr #(
   parameter int unsigned WORDS_PER_BLOCK = sd_mgr_pkg::WORDS_PER_BLOCK,
   parameter int unsigned ADDR_W          = sd_mgr_pkg::ADDR_W,
   parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
   input  logic               clk_50,
   input  logic               reset_n,
   input  logic               block_read_act,
   input  logic [31:0]        block_read_addr,
   input  logic               block_read_stop,
   output logic               block_read_go,
   input  logic               block_write_act,
   input  logic [31:0]        block_write_addr,
   output logic               block_write_done,
   output logic [ADDR_W-1:0]  bram_rd_mgr_addr,
   output logic [31:0]        bram_rd_mgr_data,
   output logic               bram_rd_mgr_wren,
   output logic [ADDR_W-1:0]  bram_wr_mgr_addr,
   input  logic [31:0]        bram_wr_mgr_q,
   output logic               host_req_valid,
   input  logic               host_req_ready,
   output logic               host_req_write,
   output logic [31:0]        host_req_lba,
   input  logic               host_rd_valid,
   input  logic [31:0]        host_rd_data,
   output logic               host_wr_valid,
   input  logic               host_wr_ready,
   output logic [31:0]        host_wr_data,
   input  logic               host_wr_ack,
   output logic               busy,
   output logic               err_timeout
);
   import sd_mgr_pkg::*;

   if (TIMEOUT_CYCLES == 0 || (1 << ADDR_W) != WORDS_PER_BLOCK) begin : g_bad_cfg
      $error("sd_block_mgr: invalid WORDS_PER_BLOCK/ADDR_W/TIMEOUT_CYCLES");
   end

   state_t              state, state_nx;
   logic                rd_act_q, wr_act_q, rd_rise, wr_rise;
   logic                rd_pend, wr_pend, take_rd, take_wr;
   logic [LBA_W-1:0]    rd_lba, wr_lba, req_lba;
   logic [ADDR_W-1:0]   wcnt;
   logic                rd_abort, fill_word, fill_end;
   logic                timeout_hit;
   logic                st_valid, st_ready, st_last;
   logic [WORD_W-1:0]   st_data;

   assign rd_rise          = block_read_act & ~rd_act_q;
   assign wr_rise          = block_write_act & ~wr_act_q;
   assign fill_word        = (state == RD_FILL) & host_rd_valid;
   assign fill_end         = fill_word & (wcnt == ADDR_W'(WORDS_PER_BLOCK - 1));
   assign busy             = (state != IDLE);
   assign host_req_lba     = req_lba;
   assign bram_rd_mgr_addr = wcnt;
   assign bram_rd_mgr_data = bram_rd_mgr_wren ? host_rd_data : '0;
   assign st_ready         = (state == WR_STREAM) & host_wr_ready & ~timeout_hit;
   assign host_wr_valid    = (state == WR_STREAM) & st_valid & ~timeout_hit;
   assign host_wr_data     = host_wr_valid ? st_data : '0;

   sd_mgr_wr_stream #(
      .WORDS (WORDS_PER_BLOCK),
      .AW    (ADDR_W)
   ) u_wr_stream (
      .clk       (clk_50),
      .reset_n   (reset_n),
      .start     ((state == WR_REQ) & host_req_valid & host_req_ready),
      .clear     (timeout_hit),
      .bram_q    (bram_wr_mgr_q),
      .bram_addr (bram_wr_mgr_addr),
      .valid     (st_valid),
      .ready     (st_ready),
      .data      (st_data),
      .last      (st_last)
   );

   always_ff @(posedge clk_50) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx         = state;
      take_rd          = 1'b0;
      take_wr          = 1'b0;
      host_req_valid   = 1'b0;
      host_req_write   = 1'b0;
      block_read_go    = 1'b0;
      block_write_done = 1'b0;
      bram_rd_mgr_wren = 1'b0;
      case (state)
         IDLE: begin
            if (rd_pend) begin
               take_rd  = 1'b1;
               state_nx = RD_REQ;
            end else if (wr_pend) begin
               take_wr  = 1'b1;
               state_nx = WR_REQ;
            end
         end
         RD_REQ: begin
            host_req_valid = ~timeout_hit;
            if (block_read_stop)                     state_nx = IDLE;
            else if (timeout_hit)                    state_nx = RD_GO;
            else if (host_req_ready)                 state_nx = RD_FILL;
         end
         RD_FILL: begin
            // After a stop the rest of the block is still drained from the host.
            bram_rd_mgr_wren = host_rd_valid & ~rd_abort & ~block_read_stop;
            if (fill_end)         state_nx = (rd_abort | block_read_stop) ? IDLE : RD_GO;
            else if (timeout_hit) state_nx = RD_GO;
         end
         RD_GO: begin
            block_read_go = 1'b1;
            state_nx      = IDLE;
         end
         WR_REQ: begin
            host_req_valid = ~timeout_hit;
            host_req_write = 1'b1;
            if (timeout_hit)         state_nx = WR_DONE;
            else if (host_req_ready) state_nx = WR_STREAM;
         end
         WR_STREAM: begin
            if (st_last)          state_nx = WR_ACK;
            else if (timeout_hit) state_nx = WR_DONE;
         end
         WR_ACK: begin
            if (host_wr_ack || timeout_hit) state_nx = WR_DONE;
         end
         WR_DONE: begin
            block_write_done = 1'b1;
            state_nx         = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_50) begin
      if (!reset_n) begin
         rd_act_q <= 1'b0;
         wr_act_q <= 1'b0;
         rd_pend  <= 1'b0;
         wr_pend  <= 1'b0;
         rd_lba   <= '0;
         wr_lba   <= '0;
         req_lba  <= '0;
         wcnt     <= '0;
         rd_abort <= 1'b0;
      end else begin
         rd_act_q <= block_read_act;
         wr_act_q <= block_write_act;
         if (rd_rise) rd_lba <= block_read_addr;
         if (wr_rise) wr_lba <= block_write_addr;
         rd_pend <= rd_rise | (rd_pend & ~take_rd);
         wr_pend <= wr_rise | (wr_pend & ~take_wr);
         if (take_rd) begin
            req_lba  <= rd_lba;
            wcnt     <= '0;
            rd_abort <= 1'b0;
         end
         if (take_wr) req_lba <= wr_lba;
         if (fill_word) wcnt <= wcnt + ADDR_W'(1);
         if ((state == RD_FILL) && block_read_stop) rd_abort <= 1'b1;
      end
   end

`ifdef SD_MGR_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tcnt;
   logic          tmo_active, hs_any;

   assign tmo_active  = state inside {RD_REQ, RD_FILL, WR_REQ, WR_STREAM, WR_ACK};
   assign hs_any      = (host_req_valid & host_req_ready) | fill_word |
                        (host_wr_valid & host_wr_ready) | ((state == WR_ACK) & host_wr_ack);
   assign timeout_hit = tmo_active & (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_50) begin
      if (!reset_n || !tmo_active || hs_any) tcnt <= '0;
      else                                   tcnt <= tcnt + TW'(1);
   end

   always_ff @(posedge clk_50) begin
      if (!reset_n)                              err_timeout <= 1'b0;
      else if (timeout_hit)                      err_timeout <= 1'b1;
      else if (host_req_valid && host_req_ready) err_timeout <= 1'b0;
   end
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule
